// File: rtl/morse_symbol_timer.sv
// Morse key front end: synchronises the key, times presses and gaps, classifies
// dit/dash and assembles per-letter code words with letter/word gap events.
module morse_symbol_timer #(
  parameter int CNT_W      = 16,
  parameter int MIN_PRESS  = 2,
  parameter int DASH_MIN   = 7,
  parameter int LETTER_GAP = 12,
  parameter int WORD_GAP   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       sym_valid,
  output logic       sym_is_dash,
  output logic       letter_valid,
  output logic [5:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       word_valid,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WAIT_WORD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] LETTER_C   = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_C     = CNT_W'(WORD_GAP);

  state_t           state_q, state_d;
  logic             key_meta_q, key_meta_d;
  logic             key_s_q, key_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [5:0]       shift_q, shift_d;
  logic [2:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             is_dash;

  logic             sym_valid_q, sym_valid_d;
  logic             sym_is_dash_q, sym_is_dash_d;
  logic             letter_valid_q, letter_valid_d;
  logic [5:0]       letter_code_q, letter_code_d;
  logic [2:0]       letter_len_q, letter_len_d;
  logic             letter_err_q, letter_err_d;
  logic             word_valid_q, word_valid_d;

  // Counter saturates so an over-long press stays classified as a dash.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign is_dash = (cnt_q >= DASH_C);

  always_comb begin
    key_meta_d     = key_in;
    key_s_d        = key_meta_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    sym_valid_d    = 1'b0;
    sym_is_dash_d  = sym_is_dash_q;
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code_q;
    letter_len_d   = letter_len_q;
    letter_err_d   = letter_err_q;
    word_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS: begin
        if (key_s_q) begin
          cnt_d = cnt_inc;
        end else if (cnt_q < MIN_C) begin
          // Glitch: resume the gap if a letter is open, otherwise drop back.
          cnt_d   = CNT_ONE;
          state_d = (len_q != 3'd0) ? GAP : IDLE;
        end else begin
          sym_valid_d   = 1'b1;
          sym_is_dash_d = is_dash;
          if (len_q < 3'd6) begin
            shift_d = {shift_q[4:0], is_dash};
            len_d   = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          cnt_d   = CNT_ONE;
          state_d = GAP;
        end
      end
      GAP: begin
        if (key_s_q) begin
          state_d = PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LETTER_C) begin
            letter_valid_d = 1'b1;
            letter_code_d  = shift_q;
            letter_len_d   = len_q;
            letter_err_d   = ovf_q;
            shift_d        = 6'd0;
            len_d          = 3'd0;
            ovf_d          = 1'b0;
            state_d        = WAIT_WORD;
          end
        end
      end
      WAIT_WORD: begin
        if (key_s_q) begin
          state_d = PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= WORD_C) begin
            word_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      key_meta_q     <= 1'b0;
      key_s_q        <= 1'b0;
      cnt_q          <= '0;
      shift_q        <= 6'd0;
      len_q          <= 3'd0;
      ovf_q          <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_is_dash_q  <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_code_q  <= 6'd0;
      letter_len_q   <= 3'd0;
      letter_err_q   <= 1'b0;
      word_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_meta_q     <= key_meta_d;
      key_s_q        <= key_s_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      len_q          <= len_d;
      ovf_q          <= ovf_d;
      sym_valid_q    <= sym_valid_d;
      sym_is_dash_q  <= sym_is_dash_d;
      letter_valid_q <= letter_valid_d;
      letter_code_q  <= letter_code_d;
      letter_len_q   <= letter_len_d;
      letter_err_q   <= letter_err_d;
      word_valid_q   <= word_valid_d;
    end
  end

  assign sym_valid    = sym_valid_q;
  assign sym_is_dash  = sym_is_dash_q;
  assign letter_valid = letter_valid_q;
  assign letter_code  = letter_code_q;
  assign letter_len   = letter_len_q;
  assign letter_err   = letter_err_q;
  assign word_valid   = word_valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Directed bench for morse_symbol_timer: table of press sequences with
// hand-computed letters, plus latency, glitch, overflow and reset sequences.
module tb_morse_symbol_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_in = 1'b0;
  logic       sym_valid, sym_is_dash, letter_valid, letter_err, word_valid;
  logic [5:0] letter_code;
  logic [2:0] letter_len;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  morse_symbol_timer dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .sym_valid(sym_valid), .sym_is_dash(sym_is_dash),
    .letter_valid(letter_valid), .letter_code(letter_code),
    .letter_len(letter_len), .letter_err(letter_err),
    .word_valid(word_valid), .state_dbg(state_dbg)
  );

  // Free-running cycle index and an event monitor sampling on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sym_total = 0, letter_total = 0, word_total = 0;
  int          last_sym_cyc = 0, last_letter_cyc = 0, last_word_cyc = 0;
  int          width_err = 0;
  logic [63:0] sym_bits = '0;
  logic        prev_sv = 1'b0, prev_lv = 1'b0, prev_wv = 1'b0;

  always @(negedge clk) begin
    if (sym_valid) begin
      sym_total    <= sym_total + 1;
      last_sym_cyc <= cyc;
      sym_bits     <= {sym_bits[62:0], sym_is_dash};
    end
    if (letter_valid) begin
      letter_total    <= letter_total + 1;
      last_letter_cyc <= cyc;
    end
    if (word_valid) begin
      word_total    <= word_total + 1;
      last_word_cyc <= cyc;
    end
    if ((sym_valid && prev_sv) || (letter_valid && prev_lv) || (word_valid && prev_wv))
      width_err <= width_err + 1;
    prev_sv <= sym_valid;
    prev_lv <= letter_valid;
    prev_wv <= word_valid;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rel_cyc = 0;
  task automatic press(input int n);
    key_in = 1'b1;
    tick(n);
    key_in = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic reset_dut();
    key_in = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  typedef logic [7:0][7:0] plen_t;

  function automatic plen_t pk(input int a0, a1, a2, a3, a4, a5, a6);
    plen_t r;
    r    = '0;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6);
    return r;
  endfunction

  typedef struct {
    int    np;
    plen_t plen;
    int    gap;
    int    tail;
    int    exp_sym;
    int    exp_bits;
    int    exp_letters;
    int    exp_len;
    int    exp_code;
    int    exp_err;
    int    exp_words;
    int    exp_state;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int s0, l0, w0, p_rel, g_rel;

  initial begin
    // H, T, W, overflow, R (length boundaries), I (gap 11), E+T (gap 12), idle glitch
    vecs[0] = '{np:4, plen:pk(6,6,6,6,0,0,0), gap:2,  tail:20, exp_sym:4, exp_bits:0,
                exp_letters:1, exp_len:4, exp_code:0, exp_err:0, exp_words:0, exp_state:3};
    vecs[1] = '{np:1, plen:pk(8,0,0,0,0,0,0), gap:2,  tail:20, exp_sym:1, exp_bits:1,
                exp_letters:1, exp_len:1, exp_code:1, exp_err:0, exp_words:0, exp_state:3};
    vecs[2] = '{np:3, plen:pk(6,8,8,0,0,0,0), gap:2,  tail:45, exp_sym:3, exp_bits:3,
                exp_letters:1, exp_len:3, exp_code:3, exp_err:0, exp_words:1, exp_state:0};
    vecs[3] = '{np:7, plen:pk(6,6,6,6,6,6,6), gap:2,  tail:20, exp_sym:7, exp_bits:0,
                exp_letters:1, exp_len:6, exp_code:0, exp_err:1, exp_words:0, exp_state:3};
    vecs[4] = '{np:3, plen:pk(2,7,6,0,0,0,0), gap:2,  tail:20, exp_sym:3, exp_bits:2,
                exp_letters:1, exp_len:3, exp_code:2, exp_err:0, exp_words:0, exp_state:3};
    vecs[5] = '{np:2, plen:pk(6,6,0,0,0,0,0), gap:11, tail:20, exp_sym:2, exp_bits:0,
                exp_letters:1, exp_len:2, exp_code:0, exp_err:0, exp_words:0, exp_state:3};
    vecs[6] = '{np:2, plen:pk(6,8,0,0,0,0,0), gap:12, tail:20, exp_sym:2, exp_bits:1,
                exp_letters:2, exp_len:1, exp_code:1, exp_err:0, exp_words:0, exp_state:3};
    vecs[7] = '{np:1, plen:pk(1,0,0,0,0,0,0), gap:2,  tail:30, exp_sym:0, exp_bits:0,
                exp_letters:0, exp_len:0, exp_code:0, exp_err:0, exp_words:0, exp_state:0};

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", int'({sym_valid, sym_is_dash, letter_valid, letter_code,
                               letter_len, letter_err, word_valid, state_dbg}), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < NV; i++) begin
      reset_dut();
      s0 = sym_total; l0 = letter_total; w0 = word_total;
      for (int k = 0; k < vecs[i].np; k++) begin
        press(int'(vecs[i].plen[k]));
        tick((k == vecs[i].np - 1) ? vecs[i].tail : vecs[i].gap);
      end
      chk($sformatf("row%0d_sym_count", i), sym_total - s0, vecs[i].exp_sym);
      if (vecs[i].exp_sym > 0)
        chk($sformatf("row%0d_sym_class", i),
            int'(sym_bits[7:0]) & ((1 << vecs[i].exp_sym) - 1), vecs[i].exp_bits);
      chk($sformatf("row%0d_letter_count", i), letter_total - l0, vecs[i].exp_letters);
      chk($sformatf("row%0d_letter_len", i), int'(letter_len), vecs[i].exp_len);
      chk($sformatf("row%0d_letter_code", i), int'(letter_code), vecs[i].exp_code);
      chk($sformatf("row%0d_letter_err", i), int'(letter_err), vecs[i].exp_err);
      chk($sformatf("row%0d_word_count", i), word_total - w0, vecs[i].exp_words);
      chk($sformatf("row%0d_state", i), int'(state_dbg), vecs[i].exp_state);
    end

    // Latency from key release to sym, letter and word events.
    reset_dut();
    press(8);
    p_rel = rel_cyc;
    tick(45);
    chk("lat_sym", last_sym_cyc - p_rel, 3);
    chk("lat_letter", last_letter_cyc - p_rel, 14);
    chk("lat_word", last_word_cyc - p_rel, 42);

    // A one-cycle pulse inside a gap restarts the gap count.
    reset_dut();
    s0 = sym_total; l0 = letter_total;
    press(6);
    tick(5);
    key_in = 1'b1;
    tick(1);
    key_in = 1'b0;
    g_rel = cyc;
    tick(20);
    chk("gap_glitch_sym_count", sym_total - s0, 1);
    chk("gap_glitch_letter_count", letter_total - l0, 1);
    chk("gap_glitch_letter_lat", last_letter_cyc - g_rel, 14);
    chk("gap_glitch_letter_len", int'(letter_len), 1);

    // Overflow flag does not leak into the following letter.
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      press(6);
      tick((k == 6) ? 20 : 2);
    end
    chk("ovf_first_err", int'(letter_err), 1);
    press(8);
    tick(20);
    chk("ovf_next_err", int'(letter_err), 0);
    chk("ovf_next_len", int'(letter_len), 1);
    chk("ovf_next_code", int'(letter_code), 1);

    // Reset in the middle of a press clears everything immediately.
    reset_dut();
    press(8);
    tick(20);
    chk("pre_reset_len", int'(letter_len), 1);
    key_in = 1'b1;
    tick(3);
    @(negedge clk);
    chk("pre_reset_state", int'(state_dbg), 1);
    #2;
    rst = 1'b1;
    key_in = 1'b0;
    #1;
    chk("mid_press_reset_outputs", int'({sym_valid, sym_is_dash, letter_valid, letter_code,
                                         letter_len, letter_err, word_valid, state_dbg}), 0);
    tick(1);
    rst = 1'b0;
    s0 = sym_total; l0 = letter_total; w0 = word_total;
    tick(60);
    chk("post_reset_sym", sym_total - s0, 0);
    chk("post_reset_letter", letter_total - l0, 0);
    chk("post_reset_word", word_total - w0, 0);
    chk("post_reset_state", int'(state_dbg), 0);

    chk("pulse_width_violations", width_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_symbol_timer.md
Name: morse_symbol_timer

Overview:
- Front-end timing stage of the Morse interpreter. Sits between the raw key input (button / JA key line) and the letter lookup / display logic.
- Synchronises the key, measures press and gap lengths in clock cycles, and classifies each press as dit or dash.
- Assembles symbols into a per-letter code word and emits one-cycle letter-complete and word-gap events to the downstream decoder.

Parameters:
- CNT_W, 16, width of the duration counter; all thresholds must be < 2^CNT_W.
- MIN_PRESS, 2, presses shorter than this many cycles are glitches and are discarded.
- DASH_MIN, 7, a press of >= DASH_MIN cycles is a dash; a press of MIN_PRESS..DASH_MIN-1 cycles is a dit.
- LETTER_GAP, 12, a low run of this many cycles ends the current letter.
- WORD_GAP, 40, a low run of this many cycles (counted from key release) signals a word gap; must exceed LETTER_GAP.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key_in  input  1  raw Morse key, asynchronous to clk
- sym_valid  output  1  one-cycle pulse: a symbol was classified
- sym_is_dash  output  1  class of the latest symbol (1 = dash); held between pulses
- letter_valid  output  1  one-cycle pulse: a letter is complete
- letter_code  output  6  symbols of the letter, LSB-aligned, first symbol at bit letter_len-1, 1 = dash; held until next letter_valid
- letter_len  output  3  symbol count 1..6; held
- letter_err  output  1  letter had more than 6 symbols; held
- word_valid  output  1  one-cycle pulse: word gap detected
- state_dbg  output  2  current FSM state, for LEDs

Behaviour:
- Reset (asynchronous, any time, including mid-press): FSM goes to IDLE; counter, shift register, sync flops and all outputs go to 0.
- Synchroniser: 2-flop chain produces key_s. All timing below is in cycles of key_s.
- States (state_dbg encoding):
  - IDLE = 0: no letter in progress.
    - key_s = 1 -> PRESS, cnt = 1.
  - PRESS = 1: counting a press.
    - key_s = 1 -> cnt increments, saturating at 2^CNT_W - 1.
    - key_s = 0 and cnt < MIN_PRESS -> glitch: discard, no output. Go to GAP with cnt = 1 if shift length > 0, else IDLE.
    - key_s = 0 and cnt >= MIN_PRESS -> pulse sym_valid, set sym_is_dash = (cnt >= DASH_MIN).
      - If shift length < 6: code = {code[4:0], is_dash}, length + 1.
      - Else: set the sticky overflow flag; code and length unchanged.
      - Go to GAP, cnt = 1.
  - GAP = 2: letter in progress, key low.
    - key_s = 1 -> PRESS, cnt = 1, no letter emitted.
    - Else cnt increments. When the low run reaches LETTER_GAP cycles: pulse letter_valid and load letter_code, letter_len, letter_err. Clear shift register, length and overflow flag. Go to WAIT_WORD; cnt keeps counting.
  - WAIT_WORD = 3: letter emitted, key low.
    - key_s = 1 -> PRESS, cnt = 1.
    - Low run reaches WORD_GAP cycles -> pulse word_valid, go to IDLE.
- Key-rising priority: the threshold checks in GAP and WAIT_WORD apply only on cycles where key_s = 0. If key_s rises, the transition to PRESS wins.
- Latency:
  - sym_valid asserts 3 cycles after key_in falls (2 sync + 1 registered).
  - letter_valid asserts LETTER_GAP + 2 cycles after key_in falls on the last symbol.
- All outputs are registered. Pulses are exactly one cycle wide. IDLE never emits letter_valid or word_valid.
- A press longer than 2^CNT_W - 1 cycles saturates and is classified as a dash.

Test Plan (default parameters):
- Reset 1 cycle; send 4 presses of 6 cycles high / 2 low, then 20 low -> 4 sym_valid pulses, all sym_is_dash = 0; one letter_valid with letter_len = 4, letter_code = 6'b000000, letter_err = 0 (H).
- Press of 8 cycles high, then 20 low -> sym_valid with sym_is_dash = 1; letter_valid with letter_len = 1, letter_code = 6'b000001 (T).
- Send dit, dash, dash (6/8/8 high, 2-cycle gaps), then 45 low -> letter_len = 3, letter_code = 6'b000011 (W); word_valid pulses exactly once, 40 cycles after the final release + 2; state_dbg returns to 0.
- 1-cycle key_in pulse in IDLE, and another 1-cycle pulse inside a letter's gap -> no sym_valid. The first leaves the FSM in IDLE; the second restarts the gap count, so letter_valid is delayed accordingly.
- 7 dits then 20 low -> 7 sym_valid pulses; letter_valid with letter_len = 6, letter_code = 6'b000000, letter_err = 1. The next letter reports letter_err = 0.
- Assert rst during the 4th cycle of a press -> all outputs 0 immediately. After release, key low for 60 cycles -> no pulses at all.
